// File: rtl/scanline_prefetcher.sv
// Scanline prefetcher: fills a ping-pong line buffer from frame-buffer memory one
// line ahead of scanout, and holds the 16-entry palette read by the color mapper.
module scanline_prefetcher #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int V_TOTAL        = 525,
    parameter int WORDS_PER_LINE = 160,
    parameter int ADDR_W         = 20,
    parameter int FB_BASE        = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [15:0]       CACHE_DATA,
    input  logic [3:0]        PALETTE_INDEX,
    output logic [11:0]       PALETTE_NOW,
    input  logic              pal_we,
    input  logic [3:0]        pal_waddr,
    input  logic [11:0]       pal_wdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              underrun,
    input  logic              underrun_clr
);
    localparam int WC_W = $clog2(WORDS_PER_LINE);
    localparam logic [9:0]      X_END   = 10'(H_ACTIVE);
    localparam logic [9:0]      Y_END   = 10'(V_ACTIVE);
    localparam logic [9:0]      Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]      Y_WRAP  = 10'(V_TOTAL - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t            state_q, state_d;
    logic [9:0]        target_q, target_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [9:0]        prev_x;
    logic              trigger;
    logic              target_ok;
    logic [9:0]        new_target;
    logic              overrun;

    // One pulse per line: DrawX may sit at H_ACTIVE for several clocks.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        new_target = '0;
        target_ok  = 1'b0;
        trigger    = (DrawX == X_END) && (prev_x != X_END);
        if (DrawY < Y_LAST) begin
            new_target = DrawY + 10'd1;
            target_ok  = 1'b1;
        end else if (DrawY == Y_WRAP) begin
            new_target = '0;
            target_ok  = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        wc_d     = wc_q;
        overrun  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger && target_ok) begin
                    state_d  = FETCH;
                    target_d = new_target;
                    wc_d     = '0;
                end
            end
            FETCH: begin
                // A new line request abandons the unfinished one.
                if (trigger) begin
                    overrun = 1'b1;
                    if (target_ok) begin
                        target_d = new_target;
                        wc_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (mem_ack) begin
                    if (wc_q == WC_LAST) state_d = DONE;
                    else                 wc_d    = wc_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        prev_x <= DrawX;
        if (Reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            wc_q     <= '0;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            wc_q     <= wc_d;
            if (overrun)           underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

    logic [ADDR_W-1:0] t_ext;
    assign t_ext    = ADDR_W'(target_q);
    assign mem_req  = (state_q == FETCH);
    assign mem_addr = mem_req ? ADDR_W'(FB_BASE) + (t_ext << 7) + (t_ext << 5) + ADDR_W'(wc_q) : '0;

    logic [15:0] line_buf [2][WORDS_PER_LINE];

    // NOTE: the line buffer is storage, not control state, so it is deliberately never reset.
    always_ff @(posedge Clk) begin
        if (!Reset && state_q == FETCH && mem_ack)
            line_buf[target_q[0]][wc_q] <= mem_rdata;
    end

    logic            rd_valid;
    logic [WC_W-1:0] rd_word;
    assign rd_valid = (DrawX < X_END) && (DrawY < Y_END);
    assign rd_word  = WC_W'(DrawX[9:2]);

    always_ff @(posedge Clk) begin
        if (Reset)         CACHE_DATA <= '0;
        else if (rd_valid) CACHE_DATA <= line_buf[DrawY[0]][rd_word];
        else               CACHE_DATA <= '0;
    end

    logic [11:0] pal [16];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) pal[i] <= '0;
        end else if (pal_we) begin
            pal[pal_waddr] <= pal_wdata;
        end
    end

    assign PALETTE_NOW = pal[PALETTE_INDEX];

endmodule

// File: tb/tb_scanline_prefetcher.sv
// Bench for scanline_prefetcher: the bench plays frame-buffer memory and checks
// fetched lines, scanout reads, palette and underrun against a plain model.
module tb_scanline_prefetcher;
    localparam int WPL = 160;
    localparam int FB  = 0;

    logic        Clk;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic [15:0] CACHE_DATA;
    logic [3:0]  PALETTE_INDEX;
    logic [11:0] PALETTE_NOW;
    logic        pal_we;
    logic [3:0]  pal_waddr;
    logic [11:0] pal_wdata;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        underrun;
    logic        underrun_clr;

    scanline_prefetcher dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .CACHE_DATA(CACHE_DATA),
        .PALETTE_INDEX(PALETTE_INDEX), .PALETTE_NOW(PALETTE_NOW),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] fb_mem [int];
    logic [11:0] pal_model [16];
    int          req_addr [$];
    bit          req_ack [$];

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Memory contents: either the word index within its line, or a random word remembered per address.
    function automatic logic [15:0] mem_word(input int a, input bit wc_data);
        if (wc_data) fb_mem[a] = 16'((a - FB) % WPL);
        else if (!fb_mem.exists(a)) fb_mem[a] = 16'($urandom);
        return fb_mem[a];
    endfunction

    // Acts as memory while mem_req is high, logging each request cycle.
    task automatic serve(input int ack_pct, input int max_cycles, input bit wc_data);
        req_addr.delete();
        req_ack.delete();
        for (int c = 0; c < max_cycles; c++) begin
            if (!mem_req) break;
            req_addr.push_back(int'(mem_addr));
            if ($urandom_range(99) < ack_pct) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(int'(mem_addr), wc_data);
                req_ack.push_back(1'b1);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                req_ack.push_back(1'b0);
            end
            step();
        end
        mem_ack = 1'b0;
    endtask

    task automatic trigger_at(input int y);
        DrawY = 10'(y);
        DrawX = 10'd639;
        step();
        DrawX = 10'd640;
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            pal_we = 1'b1; pal_waddr = 4'(i); pal_wdata = 12'($urandom_range(1, 4095));
            step();
        end
        pal_we  = 1'b0;
        mem_ack = 1'b0;
        trigger_at(10);
        trigger_at(12);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL pre_reset_req: got %0b expected 1", mem_req); end
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL pre_reset_underrun: got %0b expected 1", underrun); end
        Reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h1234; DrawY = 10'd11; DrawX = 10'd8;
        step();
        step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b expected 0", mem_req); end
        checks++; if (mem_addr !== 20'd0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
        checks++; if (CACHE_DATA !== 16'd0) begin failures++; $display("FAIL reset_cache: got %0h expected 0", CACHE_DATA); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %0b expected 0", underrun); end
        for (int i = 0; i < 16; i++) begin
            PALETTE_INDEX = 4'(i);
            #1;
            checks++; if (PALETTE_NOW !== 12'h000) begin failures++; $display("FAIL reset_pal[%0d]: got %0h expected 000", i, PALETTE_NOW); end
            pal_model[i] = 12'h000;
        end
        Reset = 1'b0;
        step();
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL post_reset_req: got %0b expected 0", mem_req); end
    endtask

    task automatic test_palette();
        PALETTE_INDEX = 4'd5; pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 12'hF80;
        #1;
        checks++; if (PALETTE_NOW !== 12'h000) begin failures++; $display("FAIL pal_write_cycle: got %0h expected 000", PALETTE_NOW); end
        step();
        pal_we = 1'b0;
        pal_model[5] = 12'hF80;
        #1;
        checks++; if (PALETTE_NOW !== 12'hF80) begin failures++; $display("FAIL pal_next_cycle: got %0h expected F80", PALETTE_NOW); end
        for (int n = 0; n < 40; n++) begin
            pal_we    = 1'($urandom_range(1));
            pal_waddr = 4'($urandom_range(15));
            pal_wdata = 12'($urandom);
            PALETTE_INDEX = ($urandom_range(1) == 1) ? pal_waddr : 4'($urandom_range(15));
            #1;
            checks++;
            if (PALETTE_NOW !== pal_model[PALETTE_INDEX]) begin
                failures++;
                $display("FAIL pal_random[%0d] idx=%0d: got %0h expected %0h", n, PALETTE_INDEX, PALETTE_NOW, pal_model[PALETTE_INDEX]);
            end
            step();
            if (pal_we) pal_model[pal_waddr] = pal_wdata;
        end
        pal_we = 1'b0;
    endtask

    task automatic test_fetch_line();
        DrawY = 10'd10; DrawX = 10'd639;
        step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_req_before: got %0b expected 0", mem_req); end
        DrawX = 10'd640;
        step();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_req_rise: got %0b expected 1", mem_req); end
        checks++; if (mem_addr !== 20'h6E0) begin failures++; $display("FAIL fetch_first_addr: got %0h expected 6e0", mem_addr); end
        serve(100, 400, 1'b1);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_req_drop: got %0b expected 0", mem_req); end
        checks++; if (req_addr.size() !== WPL) begin failures++; $display("FAIL fetch_ack_count: got %0d expected %0d", req_addr.size(), WPL); end
        if (req_addr.size() == WPL) begin
            checks++; if (req_addr[WPL-1] !== 'h77F) begin failures++; $display("FAIL fetch_last_addr: got %0h expected 77f", req_addr[WPL-1]); end
        end
        begin
            int bad = 0;
            for (int i = 0; i < req_addr.size(); i++) if (req_addr[i] != 'h6E0 + i) bad++;
            checks++; if (bad !== 0) begin failures++; $display("FAIL fetch_addr_seq: got %0d bad addresses expected 0", bad); end
        end
        step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_idle_after: got %0b expected 0", mem_req); end
    endtask

    task automatic test_read_path();
        DrawY = 10'd11; DrawX = 10'd8;
        step();
        checks++; if (CACHE_DATA !== 16'h0002) begin failures++; $display("FAIL read_x8: got %0h expected 0002", CACHE_DATA); end
        DrawX = 10'd700;
        step();
        checks++; if (CACHE_DATA !== 16'h0000) begin failures++; $display("FAIL read_x700: got %0h expected 0000", CACHE_DATA); end
        DrawX = 10'd639;
        step();
        checks++; if (CACHE_DATA !== 16'd159) begin failures++; $display("FAIL read_x639: got %0h expected 9f", CACHE_DATA); end
        for (int n = 0; n < 10; n++) begin
            int x = int'($urandom_range(639));
            DrawX = 10'(x);
            step();
            checks++; if (CACHE_DATA !== 16'(x / 4)) begin failures++; $display("FAIL read_random x=%0d: got %0h expected %0h", x, CACHE_DATA, x / 4); end
        end
        DrawY = 10'd500; DrawX = 10'd8;
        step();
        checks++; if (CACHE_DATA !== 16'h0000) begin failures++; $display("FAIL read_vblank: got %0h expected 0000", CACHE_DATA); end
    endtask

    task automatic test_frame_wrap();
        trigger_at(524);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL wrap_req: got %0b expected 1", mem_req); end
        checks++; if (mem_addr !== 20'(FB)) begin failures++; $display("FAIL wrap_addr: got %0h expected %0h", mem_addr, FB); end
        serve(100, 400, 1'b0);
        checks++; if (req_addr.size() !== WPL || mem_req !== 1'b0) begin failures++; $display("FAIL wrap_done: got %0d reqs req=%0b expected %0d reqs req=0", req_addr.size(), mem_req, WPL); end
        DrawY = 10'd0;
        for (int n = 0; n < 4; n++) begin
            int x = int'($urandom_range(639));
            DrawX = 10'(x);
            step();
            checks++; if (CACHE_DATA !== fb_mem[FB + x / 4]) begin failures++; $display("FAIL wrap_read x=%0d: got %0h expected %0h", x, CACHE_DATA, fb_mem[FB + x / 4]); end
        end
        trigger_at(479);
        for (int n = 0; n < 4; n++) begin
            checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL no_fetch_479 cyc%0d: got %0b expected 0", n, mem_req); end
            step();
        end
        trigger_at(500);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL no_fetch_500: got %0b expected 0", mem_req); end
    endtask

    task automatic test_overrun();
        trigger_at(20);
        serve(100, 5, 1'b0);
        checks++; if (mem_addr !== 20'(21 * WPL + 5)) begin failures++; $display("FAIL ovr_partial_addr: got %0h expected %0h", mem_addr, 21 * WPL + 5); end
        step();
        checks++; if (mem_addr !== 20'(21 * WPL + 5)) begin failures++; $display("FAIL ovr_addr_hold: got %0h expected %0h", mem_addr, 21 * WPL + 5); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL ovr_before: got %0b expected 0", underrun); end
        trigger_at(30);
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %0b expected 1", underrun); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 20'(31 * WPL)) begin failures++; $display("FAIL ovr_restart: got req=%0b addr=%0h expected req=1 addr=%0h", mem_req, mem_addr, 31 * WPL); end
        step();
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %0b expected 1", underrun); end
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL ovr_clr: got %0b expected 0", underrun); end
        DrawY = 10'd40; DrawX = 10'd639;
        step();
        DrawX = 10'd640; underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ovr_set_beats_clr: got %0b expected 1", underrun); end
        checks++; if (mem_addr !== 20'(41 * WPL)) begin failures++; $display("FAIL ovr_restart2: got %0h expected %0h", mem_addr, 41 * WPL); end
        trigger_at(479);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ovr_invalid_idle: got %0b expected 0", mem_req); end
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL ovr_final_clr: got %0b expected 0", underrun); end
    endtask

    task automatic test_random_lines();
        for (int it = 0; it < 6; it++) begin
            int y    = (it == 0) ? 478 : int'($urandom_range(477));
            int pct  = (it == 0) ? 100 : int'($urandom_range(30, 100));
            int base = FB + (y + 1) * WPL;
            int nack = 0;
            int bad_seq = 0;
            int bad_hold = 0;
            trigger_at(y);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 20'(base)) begin failures++; $display("FAIL rnd_start y=%0d: got req=%0b addr=%0h expected req=1 addr=%0h", y, mem_req, mem_addr, base); end
            serve(pct, 3000, 1'b0);
            checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rnd_timeout y=%0d: got req=%0b expected 0", y, mem_req); end
            for (int i = 0; i < req_addr.size(); i++) begin
                if (req_ack[i]) begin
                    if (req_addr[i] != base + nack) bad_seq++;
                    nack++;
                end else if (i + 1 < req_addr.size() && req_addr[i + 1] != req_addr[i]) begin
                    bad_hold++;
                end
            end
            checks++; if (nack !== WPL) begin failures++; $display("FAIL rnd_acks y=%0d: got %0d expected %0d", y, nack, WPL); end
            checks++; if (bad_seq !== 0) begin failures++; $display("FAIL rnd_addr_seq y=%0d: got %0d bad expected 0", y, bad_seq); end
            checks++; if (bad_hold !== 0) begin failures++; $display("FAIL rnd_addr_hold y=%0d: got %0d unstable expected 0", y, bad_hold); end
            checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rnd_underrun y=%0d: got %0b expected 0", y, underrun); end
            DrawY = 10'(y + 1);
            for (int n = 0; n < 8; n++) begin
                int x = (n == 0) ? 0 : (n == 1) ? 639 : int'($urandom_range(639));
                DrawX = 10'(x);
                step();
                checks++;
                if (CACHE_DATA !== fb_mem[base + x / 4]) begin
                    failures++;
                    $display("FAIL rnd_read y=%0d x=%0d: got %0h expected %0h", y + 1, x, CACHE_DATA, fb_mem[base + x / 4]);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; PALETTE_INDEX = '0;
        pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; underrun_clr = 1'b0;
        for (int i = 0; i < 16; i++) pal_model[i] = 12'h000;
        step();
        step();
        Reset = 1'b0;
        step();
        test_reset();
        test_palette();
        test_fetch_line();
        test_read_path();
        test_frame_wrap();
        test_overrun();
        test_random_lines();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scanline_prefetcher.md
Name: scanline_prefetcher

Overview:
- Supplies `CACHE_DATA` (one 16-bit frame-buffer word, four 4-bit pixel indices) and `PALETTE_NOW` (a 12-bit RGB color) to the color mapper.
- Prefetches the next visible scanline from frame-buffer memory into a ping-pong line buffer while the current line is scanned out.
- Holds the 16-entry palette register file, which the CPU writes and the color mapper reads through `PALETTE_INDEX`.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- V_TOTAL, 525, total lines per frame, including vertical blanking.
- WORDS_PER_LINE, 160, words per line; equals H_ACTIVE/4.
- ADDR_W, 20, memory word-address width.
- FB_BASE, 0, word address of line 0 of the frame buffer.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current line from the VGA controller.
- CACHE_DATA  out  16  word containing pixel DrawX of line DrawY.
- PALETTE_INDEX  in  4  palette entry requested by the color mapper.
- PALETTE_NOW  out  12  RGB value of the selected entry: [11:8] R, [7:4] G, [3:0] B.
- pal_we  in  1  palette write strobe.
- pal_waddr  in  4  palette write index.
- pal_wdata  in  12  palette write data.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  memory read word address.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  16  memory read data.
- underrun  out  1  sticky flag: a line fetch did not finish in time.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=0, CACHE_DATA=0, underrun=0.
  - FSM goes to IDLE; word counter is 0.
  - All palette entries are 0x000.
  - Line-buffer contents are unspecified after reset and are not cleared.
- Fetch trigger:
  - DrawX is registered each clock as prevX.
  - trigger = (DrawX==H_ACTIVE) && (prevX!=H_ACTIVE), so exactly one pulse per line even when the pixel rate is below Clk.
- Target line on trigger:
  - DrawY < V_ACTIVE-1: target = DrawY+1.
  - DrawY == V_TOTAL-1: target = 0.
  - Any other DrawY: no fetch.
- Buffer banks:
  - Two banks, each WORDS_PER_LINE x 16.
  - The write bank is target[0]; the read bank is DrawY[0].
- FSM states IDLE, FETCH, DONE:
  - IDLE: on trigger with a valid target, latch the target, set word counter wc=0, go to FETCH.
  - FETCH: mem_req=1 and mem_addr = FB_BASE + target*WORDS_PER_LINE + wc. The multiply is implemented as (t<<7)+(t<<5), computed at ADDR_W width.
  - FETCH, on mem_ack: write mem_rdata to bank[target[0]][wc].
    - If wc == WORDS_PER_LINE-1, go to DONE.
    - Otherwise wc++ and the address updates in the next cycle.
  - mem_addr is stable while mem_req=1 and no ack has arrived.
  - DONE: mem_req=0 for one cycle, then IDLE.
  - mem_ack seen outside FETCH is ignored.
- Trigger during FETCH (overrun):
  - Set underrun.
  - Abandon the current line and restart FETCH for the new target with wc=0; the address changes in the next cycle.
  - If the new target is invalid, go to IDLE.
- underrun flag:
  - Set has priority over underrun_clr when both occur in the same cycle.
  - Otherwise underrun_clr clears it.
- Read path:
  - Registered, 1-clock latency: CACHE_DATA <= bank[DrawY[0]][DrawX[9:2]] when DrawX < H_ACTIVE and DrawY < V_ACTIVE, else 0.
  - A read and a write to the same bank in the same cycle never conflict by construction. If they do occur, the read returns the old data.
- Palette:
  - PALETTE_NOW = pal[PALETTE_INDEX] as a combinational read.
  - The write is registered: the new value is visible in the cycle after the pal_we edge.
  - A write and a read of the same index in the same cycle return the old value.
- Reset mid-fetch: on the next edge, mem_req=0 and FSM=IDLE. A pending ack is ignored.

Test Plan:
- Reset asserted for 2 clocks during FETCH -> mem_req=0, CACHE_DATA=0, underrun=0, PALETTE_NOW=0x000 for every index.
- pal_we=1, pal_waddr=5, pal_wdata=0xF80, with PALETTE_INDEX=5 -> PALETTE_NOW=0x000 in the write cycle and 0xF80 in the next cycle.
- DrawY=10, DrawX stepping 639->640, mem_ack every cycle, mem_rdata=wc -> mem_req rises 1 clock after the trigger; addresses run 0x6E0..0x77F; 160 acks; mem_req drops after the last ack.
- Continue from the previous case with DrawY=11, DrawX=8 -> CACHE_DATA=0x0002 one clock later. DrawX=700 -> CACHE_DATA=0.
- Trigger at DrawY=524 -> fetch target 0, first mem_addr=FB_BASE. Trigger at DrawY=479 -> mem_req stays 0.
- mem_ack held low across the next trigger -> underrun=1 and mem_addr jumps to the new line's base with wc=0. underrun_clr pulse -> underrun=0. A simultaneous trigger-overrun and clr -> underrun stays 1.
